// File: rtl/data_sram_arbiter.sv
// Two-master arbiter for the single-port synchronous data SRAM.
// One access is granted per cycle. Each response returns on the owner's
// port exactly one cycle after its grant.
module data_sram_arbiter #(
  parameter int unsigned PRIO_MODE  = 0,  // 0: round-robin, 1: m0 priority + starvation guard
  parameter int unsigned STARVE_MAX = 4   // PRIO_MODE=1: m0 grants in a row before m1 is forced
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,

  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  // Set in reset, cleared one cycle later; keeps every output quiet for that first cycle.
  logic       init_q;
  logic       blank;
  // Round-robin: 1 when m1 won the last grant (reset value makes m0 preferred).
  logic       last_m1_q, last_m1_d;
  // Consecutive m0 grants while m1 was waiting.
  logic [3:0] starve_q, starve_d;
  logic       gnt0, gnt1;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_owner_q, resp_owner_d;    // 1 = m1
  logic       resp_is_load_q, resp_is_load_d;

  assign blank = reset | init_q;

  // Grant decision for the current cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!blank) begin
      if (PRIO_MODE == 0) begin
        if (m0_req && m1_req) begin
          gnt0 = last_m1_q;
          gnt1 = !last_m1_q;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end else begin
        if (m1_req && (!m0_req || starve_q == StarveMax)) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = m0_req;
        end
      end
    end
  end

  // Next-state for the fairness state and the response tracker.
  always_comb begin
    last_m1_d      = last_m1_q;
    starve_d       = starve_q;
    resp_valid_d   = gnt0 | gnt1;
    resp_owner_d   = gnt1;
    resp_is_load_d = gnt1 ? !m1_wr : !m0_wr;

    if (gnt0) begin
      last_m1_d = 1'b0;
    end else if (gnt1) begin
      last_m1_d = 1'b1;
    end

    if (!m1_req || gnt1) begin
      starve_d = 4'd0;
    end else if (gnt0 && starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers with synchronous reset; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_q         <= 1'b1;
      last_m1_q      <= 1'b1;
      starve_q       <= 4'd0;
      resp_valid_q   <= 1'b0;
      resp_owner_q   <= 1'b0;
      resp_is_load_q <= 1'b0;
    end else begin
      init_q         <= 1'b0;
      last_m1_q      <= last_m1_d;
      starve_q       <= starve_d;
      resp_valid_q   <= resp_valid_d;
      resp_owner_q   <= resp_owner_d;
      resp_is_load_q <= resp_is_load_d;
    end
  end

  // Accept strobes and SRAM port drive from the winner.
  always_comb begin
    m0_addr_ok      = gnt0;
    m1_addr_ok      = gnt1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    if (gnt1) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = m1_wr ? m1_wstrb : 4'h0;
      data_sram_addr  = m1_addr;
      data_sram_wdata = m1_wdata;
    end else if (gnt0) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = m0_wr ? m0_wstrb : 4'h0;
      data_sram_addr  = m0_addr;
      data_sram_wdata = m0_wdata;
    end
  end

  // Route the one-cycle-late response to its owner; stores return zero data.
  always_comb begin
    m0_data_ok = 1'b0;
    m1_data_ok = 1'b0;
    m0_rdata   = 32'h0;
    m1_rdata   = 32'h0;
    if (resp_valid_q && !reset) begin
      if (resp_owner_q) begin
        m1_data_ok = 1'b1;
        m1_rdata   = resp_is_load_q ? data_sram_rdata : 32'h0;
      end else begin
        m0_data_ok = 1'b1;
        m0_rdata   = resp_is_load_q ? data_sram_rdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Bench for data_sram_arbiter: instance 0 runs round-robin, instance 1 runs
// fixed priority with STARVE_MAX=4. A driver applies stimulus and queues the
// expected behaviour from a reference model; a monitor compares every cycle.
module tb_data_sram_arbiter;

  typedef struct packed {
    logic        v;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    int          cyc;
    logic [70:0] v;
  } gexp_t;

  typedef struct packed {
    int          due;
    logic        owner;
    logic [31:0] rd;
  } rexp_t;

  localparam int StarveMax = 4;

  logic        clk;
  logic        rst;
  logic        mem_init;

  logic        i_req   [2][2];
  logic        i_wr    [2][2];
  logic [3:0]  i_wstrb [2][2];
  logic [31:0] i_addr  [2][2];
  logic [31:0] i_wdata [2][2];
  logic        a_ok    [2][2];
  logic        d_ok    [2][2];
  logic [31:0] rdat    [2][2];
  logic        s_en    [2];
  logic [3:0]  s_wen   [2];
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  logic [31:0] s_rdata [2];
  logic [31:0] sram_mem[2][128];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_sram_arbiter #(
      .PRIO_MODE (g),
      .STARVE_MAX(StarveMax)
    ) u_dut (
      .clk            (clk),
      .reset          (rst),
      .m0_req         (i_req[g][0]),
      .m0_wr          (i_wr[g][0]),
      .m0_wstrb       (i_wstrb[g][0]),
      .m0_addr        (i_addr[g][0]),
      .m0_wdata       (i_wdata[g][0]),
      .m0_addr_ok     (a_ok[g][0]),
      .m0_data_ok     (d_ok[g][0]),
      .m0_rdata       (rdat[g][0]),
      .m1_req         (i_req[g][1]),
      .m1_wr          (i_wr[g][1]),
      .m1_wstrb       (i_wstrb[g][1]),
      .m1_addr        (i_addr[g][1]),
      .m1_wdata       (i_wdata[g][1]),
      .m1_addr_ok     (a_ok[g][1]),
      .m1_data_ok     (d_ok[g][1]),
      .m1_rdata       (rdat[g][1]),
      .data_sram_en   (s_en[g]),
      .data_sram_wen  (s_wen[g]),
      .data_sram_addr (s_addr[g]),
      .data_sram_wdata(s_wdata[g]),
      .data_sram_rdata(s_rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 64) return 32'hDEADBEEF;
    if (i == 16) return 32'hAAAAAAAA;
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural SRAM: one-cycle read latency, written data visible to the next read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 128; i++) sram_mem[k][i] <= init_word(i);
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (s_en[k]) begin
          sram_mem[k][s_addr[k][8:2]] <= merge(sram_mem[k][s_addr[k][8:2]], s_wdata[k], s_wen[k]);
          s_rdata[k] <= merge(sram_mem[k][s_addr[k][8:2]], s_wdata[k], s_wen[k]);
        end
      end
    end
  end

  // Scoreboard and reference model state.
  int          n_pass;
  int          n_chk;
  int          drv_cyc;
  req_t        pend   [2][2];
  logic [31:0] ref_mem[2][128];
  int          last_m [2];
  int          wait_m [2];
  logic        prev_rst;
  gexp_t       exp_g  [2][$];
  rexp_t       exp_r  [2][$];
  logic [1:0]  hist   [2][$];
  int          prob_new;
  int          prob_wd;
  logic        allow_wr;

  task automatic chk(input string nm, input int k, input logic [71:0] act,
                     input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, k, drv_cyc, act, exp);
  endtask

  function automatic req_t mk_req(input logic wr, input logic [3:0] wstrb,
                                  input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.v = 1'b1; r.wr = wr; r.wstrb = wstrb; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  // Apply this cycle's inputs and queue what each instance must do with them.
  task automatic step(input logic r);
    int          win;
    logic        blank;
    logic        r0, r1;
    req_t        p;
    logic [31:0] rd;
    gexp_t       ge;
    rexp_t       re;
    drv_cyc++;
    rst   = r;
    blank = r | prev_rst;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        i_req[k][j]   = pend[k][j].v;
        i_wr[k][j]    = pend[k][j].wr;
        i_wstrb[k][j] = pend[k][j].wstrb;
        i_addr[k][j]  = pend[k][j].addr;
        i_wdata[k][j] = pend[k][j].wdata;
      end
      r0  = pend[k][0].v;
      r1  = pend[k][1].v;
      win = -1;
      if (!blank) begin
        if (k == 0) begin
          if (r0 && r1) win = 1 - last_m[k];
          else if (r0)  win = 0;
          else if (r1)  win = 1;
          if (win >= 0) last_m[k] = win;
        end else begin
          if (r1 && (!r0 || wait_m[k] == StarveMax)) win = 1;
          else if (r0) win = 0;
          if (!r1 || win == 1) wait_m[k] = 0;
          else if (win == 0 && wait_m[k] < StarveMax) wait_m[k]++;
        end
      end
      if (r) begin
        last_m[k] = 1;
        wait_m[k] = 0;
        while (exp_r[k].size() > 0 && exp_r[k][0].due == drv_cyc) void'(exp_r[k].pop_front());
      end
      ge.cyc = drv_cyc;
      ge.v   = '0;
      if (win >= 0) begin
        p = pend[k][win];
        if (p.wr) ref_mem[k][p.addr[8:2]] = merge(ref_mem[k][p.addr[8:2]], p.wdata, p.wstrb);
        rd = p.wr ? 32'h0 : ref_mem[k][p.addr[8:2]];
        ge.v = {win == 0, win == 1, 1'b1, p.wr ? p.wstrb : 4'h0, p.addr, p.wdata};
        re.due = drv_cyc + 1;
        re.owner = (win == 1);
        re.rd = rd;
        exp_r[k].push_back(re);
        pend[k][win].v = 1'b0;
      end
      exp_g[k].push_back(ge);
    end
    prev_rst = r;
  endtask

  // Random master behaviour: issue when idle, occasionally withdraw while waiting.
  task automatic refill();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        if (!pend[k][j].v) begin
          if ($urandom_range(0, 99) < prob_new)
            pend[k][j] = mk_req(allow_wr ? 1'($urandom_range(0, 1)) : 1'b0,
                                4'($urandom_range(0, 15)),
                                {23'h0, 7'($urandom_range(0, 64)), 2'b00}, $urandom);
        end else if ($urandom_range(0, 99) < prob_wd) begin
          pend[k][j].v = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle(input logic r);
    @(posedge clk);
    #1;
    refill();
    step(r);
  endtask

  // Monitor: compare grant/SRAM drive and responses against the queued expectations.
  logic [70:0] mon_g;
  logic [65:0] mon_r, mon_er;
  gexp_t       mon_ge;
  rexp_t       mon_re;
  initial begin
    forever begin
      @(negedge clk);
      if (drv_cyc > 0) begin
        for (int k = 0; k < 2; k++) begin
          mon_g = {a_ok[k][0], a_ok[k][1], s_en[k], s_wen[k], s_addr[k], s_wdata[k]};
          hist[k].push_back({a_ok[k][1], a_ok[k][0]});
          if (exp_g[k].size() > 0 && exp_g[k][0].cyc == drv_cyc) begin
            mon_ge = exp_g[k].pop_front();
            chk("grant", k, {1'b0, mon_g}, {1'b0, mon_ge.v});
          end
          mon_er = '0;
          if (exp_r[k].size() > 0 && exp_r[k][0].due == drv_cyc) begin
            mon_re = exp_r[k].pop_front();
            mon_er = mon_re.owner ? {2'b01, 32'h0, mon_re.rd} : {2'b10, mon_re.rd, 32'h0};
          end
          mon_r = {d_ok[k][0], d_ok[k][1], rdat[k][0], rdat[k][1]};
          chk("resp", k, {6'h0, mon_r}, {6'h0, mon_er});
        end
      end
    end
  end

  string       pat[2];
  logic [31:0] obs, exv;

  initial begin
    n_pass   = 0;
    n_chk    = 0;
    drv_cyc  = 0;
    prev_rst = 1'b1;
    rst      = 1'b1;
    mem_init = 1'b1;
    prob_new = 0;
    prob_wd  = 0;
    allow_wr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      last_m[k] = 1;
      wait_m[k] = 0;
      for (int i = 0; i < 128; i++) ref_mem[k][i] = init_word(i);
      for (int j = 0; j < 2; j++) begin
        pend[k][j]    = '0;
        i_req[k][j]   = 1'b0;
        i_wr[k][j]    = 1'b0;
        i_wstrb[k][j] = 4'h0;
        i_addr[k][j]  = 32'h0;
        i_wdata[k][j] = 32'h0;
      end
    end

    cycle(1'b1);
    mem_init = 1'b0;
    cycle(1'b1);
    cycle(1'b0);  // quiet cycle right after reset

    // Lone m0 load of the preloaded word.
    for (int k = 0; k < 2; k++) pend[k][0] = mk_req(1'b0, 4'h0, 32'h100, 32'h0);
    repeat (3) cycle(1'b0);

    // m1 partial store then load of the same word.
    for (int k = 0; k < 2; k++) pend[k][1] = mk_req(1'b1, 4'b0011, 32'h40, 32'h12345678);
    cycle(1'b0);
    for (int k = 0; k < 2; k++) pend[k][1] = mk_req(1'b0, 4'h0, 32'h40, 32'h0);
    repeat (3) cycle(1'b0);

    // Reset right after an m0 load grant: its response must never appear.
    for (int k = 0; k < 2; k++) pend[k][0] = mk_req(1'b0, 4'h0, 32'h8, 32'h0);
    cycle(1'b0);
    cycle(1'b1);
    repeat (2) cycle(1'b0);

    // m0 withdraws while m1 keeps requesting, then re-requests.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (i < 4) pend[k][1] = mk_req(1'b0, 4'h0, 32'h20, 32'h0);
        if (i == 0 || i == 3) pend[k][0] = mk_req(1'b0, 4'h0, 32'h10, 32'h0);
        if (i == 1 || i == 2) pend[k][0].v = 1'b0;
      end
      cycle(1'b0);
    end

    // Both masters requesting continuously straight out of reset.
    prob_new = 100;
    allow_wr = 1'b0;
    cycle(1'b1);
    cycle(1'b1);
    for (int k = 0; k < 2; k++) hist[k].delete();
    repeat (11) cycle(1'b0);
    @(negedge clk);
    #1;
    pat[0] = "--0101010101";
    pat[1] = "--0000100001";
    for (int k = 0; k < 2; k++) begin
      obs = '0;
      exv = '0;
      for (int i = 0; i < hist[k].size(); i++) obs = {obs[29:0], hist[k][i]};
      for (int i = 0; i < pat[k].len(); i++)
        exv = {exv[29:0], (pat[k][i] == 8'h30) ? 2'b01 : (pat[k][i] == 8'h31) ? 2'b10 : 2'b00};
      chk("pattern", k, {40'h0, obs}, {40'h0, exv});
    end

    // Random traffic with occasional resets.
    prob_new = 60;
    prob_wd  = 5;
    allow_wr = 1'b1;
    for (int i = 0; i < 1500; i++) cycle($urandom_range(0, 149) == 0);

    // Drain: every accepted request must have been answered.
    prob_new = 0;
    prob_wd  = 0;
    repeat (4) cycle(1'b0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("drain", k, 72'(exp_r[k].size()), 72'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_sram_arbiter.md
Name: data_sram_arbiter

Overview:
Shares the single synchronous data SRAM between two requesters: m0 (CPU exe/mem stage load/store path) and m1 (auxiliary master, e.g. debug/DMA loader). Each master uses a req/addr_ok/data_ok handshake. The SRAM has fixed 1-cycle read latency. The block arbitrates one access per cycle, drives the SRAM port, and routes each response back to its owner.

Parameters:
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority to m0 with starvation guard
STARVE_MAX, 4, PRIO_MODE=1 only: after this many consecutive m0 grants while m1 is waiting, the next grant is forced to m1 (range 1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
m0_req  input  1  m0 access request; held with fields stable until m0_addr_ok
m0_wr  input  1  1 = store, 0 = load
m0_wstrb  input  4  byte enables for a store; ignored for a load
m0_addr  input  32  byte address
m0_wdata  input  32  store data
m0_addr_ok  output  1  request accepted this cycle
m0_data_ok  output  1  response for the accepted m0 request (both loads and stores)
m0_rdata  output  32  load data, valid when m0_data_ok and the access was a load
m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata, m1_addr_ok, m1_data_ok, m1_rdata  same directions/widths/meanings as m0_*, for m1
data_sram_en  output  1  SRAM enable
data_sram_wen  output  4  SRAM byte write enables
data_sram_addr  output  32  SRAM address
data_sram_wdata  output  32  SRAM write data
data_sram_rdata  input  32  SRAM read data, valid the cycle after an enabled read

Behaviour:
- Reset: clk and reset are as stated in the port list. All outputs are 0 during reset and in the first cycle after reset.
  - Round-robin pointer resets to prefer m0.
  - Starvation counter resets to 0.
  - Any pending response is discarded; no data_ok is asserted in the cycle after reset, even if a grant occurred in the cycle before reset.
- Grant (combinational, same cycle):
  - Exactly one master is granted when any req is high.
  - mX_addr_ok = grant to X. addr_ok never rises without req.
- Round-robin (PRIO_MODE=0):
  - If both masters request, grant the one not granted last.
  - If only one requests, grant it; the pointer updates to that winner.
  - The pointer is updated only on a grant.
- Fixed priority (PRIO_MODE=1):
  - m0 wins ties.
  - The counter increments on each m0 grant while m1_req=1, saturating at STARVE_MAX.
  - The counter clears on any m1 grant, and on any cycle with m1_req=0.
  - When counter == STARVE_MAX and m1_req=1, m1 is granted even if m0_req=1.
- SRAM drive on a granted cycle:
  - data_sram_en=1, data_sram_addr = winner addr, data_sram_wdata = winner wdata.
  - data_sram_wen = winner wr ? winner wstrb : 4'h0.
  - With no grant: en=0, wen=0; addr and wdata are don't-care but driven to 0.
- Response:
  - Register resp_valid, resp_owner and resp_is_load on each grant.
  - In the next cycle, data_ok pulses for resp_owner only, for exactly 1 cycle.
  - rdata = data_sram_rdata for a load, 0 for a store. The non-owner's rdata is 0.
- Latency: grant in cycle N, then data_ok in cycle N+1, always. The block has no backpressure on data_ok; masters must accept it.
- Throughput: 1 access per cycle. A new grant in cycle N+1 coexists with the response of cycle N.
- A master may issue back-to-back requests. Its data_ok stream is in order, one per accepted request.
- An un-granted master's request stays pending with no side effects. Withdrawing req before addr_ok is legal.
- A store followed immediately by a load to the same address returns the new data; the SRAM is write-first across cycles.

Test Plan:
1. Reset, then m0 load of 0x100 alone (SRAM preloaded with 0xDEADBEEF) -> m0_addr_ok in cycle 0, en=1, wen=0; m0_data_ok=1 with m0_rdata=0xDEADBEEF in cycle 1; m1 outputs stay 0.
2. PRIO_MODE=0, both masters requesting continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; each data_ok appears one cycle after the matching grant on the correct port.
3. PRIO_MODE=1, STARVE_MAX=4, both requesting continuously -> grant pattern m0×4, m1, m0×4, m1; the counter clears after each m1 grant.
4. m1 store wstrb=4'b0011 data 0x12345678 to 0x40 over an initial 0xAAAAAAAA, then m1 load of 0x40 -> wen=4'b0011 in cycle 0; load returns 0xAAAA5678; m1_data_ok in cycles 1 and 2.
5. m0 granted (load) in cycle N with reset asserted in cycle N+1 -> no m0_data_ok in cycle N+1 or N+2; all outputs 0 through the cycle after reset.
6. m0 withdraws req while m1 holds the grant, then re-requests -> no m0_addr_ok and no SRAM access during the withdrawn period; normal grant on re-request.
